// File: rtl/req_ack_responder.sv
// Handshake target: acks each rising edge of req after lat_cfg+2 cycles, queueing up to DEPTH.
// Optional jitter on the ack latency is enabled by defining RSP_JITTER_EN.
module req_ack_responder #(
   parameter int         LAT_W     = 4,
   parameter int         DEPTH     = 4,
   parameter int         CNT_W     = 3,
   parameter int         JIT_W     = 2,
   parameter logic [7:0] LFSR_SEED = 8'hA5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req,
   input  logic [LAT_W-1:0] lat_cfg,
   output logic             ack,
   output logic             busy,
   output logic [CNT_W-1:0] pending,
   output logic             overflow
);

   localparam int CW = LAT_W + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_ACK  = 2'd2
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_load;
   logic          req_q;
   logic          rise;
   logic          dec;
   logic          full;
   logic          inc;

   assign rise = req & ~req_q;
   assign dec  = (state == S_ACK);
   assign full = (pending == CNT_W'(DEPTH));
   // a rise at full occupancy still fits when a slot frees on the same edge
   assign inc  = rise & (~full | dec);

`ifdef RSP_JITTER_EN
   logic [7:0] lfsr;

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr <= LFSR_SEED;
      end else begin
         lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      end
   end

   assign cnt_load = {1'b0, lat_cfg} + CW'(lfsr[JIT_W-1:0]);
`else
   logic unused_cfg;

   assign unused_cfg = ^{LFSR_SEED, 32'(JIT_W)};
   assign cnt_load   = {1'b0, lat_cfg};
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         cnt      <= '0;
         req_q    <= 1'b1;
         ack      <= 1'b0;
         busy     <= 1'b0;
         pending  <= '0;
         overflow <= 1'b0;
      end else begin
         req_q <= req;
         ack   <= 1'b0;

         if (inc && !dec) begin
            pending <= pending + CNT_W'(1);
         end else if (dec && !inc) begin
            pending <= pending - CNT_W'(1);
         end

         if (rise && full && !dec) begin
            overflow <= 1'b1;
         end

         unique case (state)
            S_IDLE: begin
               if (pending != '0) begin
                  state <= S_WAIT;
                  cnt   <= cnt_load;
                  busy  <= 1'b1;
               end
            end
            S_WAIT: begin
               if (cnt != '0) begin
                  cnt <= cnt - CW'(1);
               end else begin
                  state <= S_ACK;
                  ack   <= 1'b1;
               end
            end
            S_ACK: begin
               if (pending >= CNT_W'(2)) begin
                  state <= S_WAIT;
                  cnt   <= cnt_load;
               end else begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_req_ack_responder.sv
// Randomised and directed bench for req_ack_responder against a timeline model.
// Literal ack-timing checks assume RSP_JITTER_EN is undefined.
module tb_req_ack_responder;

   localparam int LAT_W = 4;
   localparam int DEPTH = 4;
   localparam int CNT_W = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic             req;
   logic [LAT_W-1:0] lat_cfg;
   logic             ack;
   logic             busy;
   logic [CNT_W-1:0] pending;
   logic             overflow;

   int vectors     = 0;
   int miscompares = 0;

   req_ack_responder #(
      .LAT_W(LAT_W),
      .DEPTH(DEPTH),
      .CNT_W(CNT_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .req(req),
      .lat_cfg(lat_cfg),
      .ack(ack),
      .busy(busy),
      .pending(pending),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   // Model: a server that starts a job at edge s and acks at s+lat+1, frees at s+lat+2
   int         cyc        = 0;
   int         m_pend     = 0;
   bit         m_busy     = 0;
   bit         m_ovf      = 0;
   bit         m_reqq     = 1;
   int         m_ack_edge = -1;
   int         m_done_edge = -1;
   logic [7:0] m_lfsr     = 8'hA5;

   always @(posedge clk) begin : model
      int pend_pre;
      bit rise;
      bit done;
      int lat;
      cyc++;
      if (rst) begin
         m_pend = 0;
         m_busy = 0;
         m_ovf  = 0;
         m_reqq = 1;
         m_ack_edge  = -1;
         m_done_edge = -1;
         m_lfsr = 8'hA5;
      end else begin
         pend_pre = m_pend;
         rise = req && !m_reqq;
         done = m_busy && (cyc == m_done_edge);
         if (rise) begin
            if (pend_pre < DEPTH || done) m_pend++;
            else m_ovf = 1;
         end
         if (done) m_pend--;
         if ((done && pend_pre >= 2) || (!m_busy && pend_pre > 0)) begin
            lat = int'(lat_cfg);
`ifdef RSP_JITTER_EN
            lat += int'(m_lfsr[1:0]);
`endif
            m_ack_edge  = cyc + lat + 1;
            m_done_edge = cyc + lat + 2;
            m_busy = 1;
         end else if (done) begin
            m_busy = 0;
         end
         m_reqq = req;
         m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
      end
   end

   always @(posedge clk) begin : compare
      bit e_ack;
      #1;
      e_ack = m_busy && (cyc == m_ack_edge);
      vectors++;
      if (ack !== e_ack || busy !== m_busy ||
          pending !== CNT_W'(m_pend) || overflow !== m_ovf) begin
         miscompares++;
         $display("FAIL cycle %0d: ack/busy/pending/overflow got %b/%b/%0d/%b want %b/%b/%0d/%b",
                  cyc, ack, busy, pending, overflow, e_ack, m_busy, m_pend, m_ovf);
      end
   end

   task automatic check_lit(input string name, input int got, input int want);
      vectors++;
      if (got != want) begin
         miscompares++;
         $display("FAIL %s: got %0d want %0d", name, got, want);
      end
   endtask

   // one stimulus step: drive req at negedge, sample #1 after the following posedge
   task automatic step(input logic r);
      @(negedge clk);
      req = r;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_test(input int l, input int w_ack, input int w_busy, input int w_pend,
                             input string name);
      int g_ack, g_busy, g_pend;
      g_ack = 0; g_busy = 0; g_pend = 0;
      @(negedge clk);
      lat_cfg = LAT_W'(l);
      for (int i = 0; i < 8; i++) begin
         step(i == 0);
         g_ack  |= int'(ack) << i;
         g_busy |= int'(busy) << i;
         g_pend |= int'(pending == 1) << i;
      end
`ifndef RSP_JITTER_EN
      check_lit({name, "_ack"}, g_ack, w_ack);
      check_lit({name, "_busy"}, g_busy, w_busy);
      check_lit({name, "_pend"}, g_pend, w_pend);
`endif
      repeat (3) step(1'b0);
   endtask

   initial begin
      int g_ack, g_busy, n_ack, dens;
      rst = 1'b1;
      req = 1'b0;
      lat_cfg = 4'd3;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      step(1'b0);
      check_lit("reset_pending", int'(pending), 0);
      check_lit("reset_busy", int'(busy), 0);
      check_lit("reset_ack", int'(ack), 0);
      check_lit("reset_overflow", int'(overflow), 0);

      pulse_test(3, 32'h20, 32'h3E, 32'h3F, "lat3");
      pulse_test(0, 32'h04, 32'h06, 32'h07, "lat0");

      // three rises two cycles apart
      lat_cfg = 4'd3;
      g_ack = 0; g_busy = 0;
      for (int i = 0; i < 20; i++) begin
         step(i <= 4 && i % 2 == 0);
         g_ack  |= int'(ack) << i;
         g_busy |= int'(busy) << i;
      end
`ifndef RSP_JITTER_EN
      check_lit("b2b_ack", g_ack, (1 << 5) | (1 << 10) | (1 << 15));
      check_lit("b2b_busy", g_busy, 32'h0000_FFFE);
`endif
      check_lit("b2b_overflow", int'(overflow), 0);

      // five rises before the first ack at L=15
      lat_cfg = 4'd15;
      n_ack = 0;
      for (int i = 0; i < 110; i++) begin
         step(i <= 8 && i % 2 == 0);
         n_ack += int'(ack);
      end
      check_lit("ovf_acks", n_ack, 4);
      check_lit("ovf_sticky", int'(overflow), 1);
      check_lit("ovf_drain", int'(pending), 0);

      // reset during WAIT with req held high through release
      for (int i = 0; i < 6; i++) step(i == 0);
      @(negedge clk);
      rst = 1'b1;
      req = 1'b1;
      @(posedge clk);
      #1;
      check_lit("rst_pending", int'(pending), 0);
      check_lit("rst_busy", int'(busy), 0);
      check_lit("rst_overflow", int'(overflow), 0);
      @(negedge clk);
      rst = 1'b0;
      n_ack = 0;
      for (int i = 0; i < 25; i++) begin
         step(1'b1);
         n_ack += int'(ack);
      end
      check_lit("rst_held_req_acks", n_ack, 0);
      step(1'b0);
      pulse_test(2, 32'h10, 32'h1E, 32'h1F, "after_rst");

      // randomised traffic
      dens = 30;
      for (int i = 0; i < 3000; i++) begin
         if (i % 500 == 0) dens = int'($urandom_range(5, 90));
         @(negedge clk);
         rst = ($urandom_range(0, 399) == 0);
         req = ($urandom_range(0, 99) < dens);
         if ($urandom_range(0, 3) == 0) lat_cfg = LAT_W'($urandom_range(0, 15));
         else if ($urandom_range(0, 7) == 0) lat_cfg = LAT_W'($urandom_range(0, 3));
      end
      @(negedge clk);
      rst = 1'b0;
      req = 1'b0;
      repeat (120) @(negedge clk);
      check_lit("final_drain", int'(pending), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
